// File: rtl/buyruk_kuyrugu.sv
// Instruction-issue stage ahead of the combinational ALU: FIFO-buffered words, one in flight,
// result held on a valid/ready output. Define ISLEM_SAYACI_EN to add the islem_sayisi handshake counter.
module buyruk_kuyrugu #(
  parameter int N        = 3,
  parameter int DERINLIK = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        giris_gecerli,
  input  logic [2*N+2:0]              giris_buyruk,
  output logic                        giris_hazir,
  output logic [2*N+2:0]              alu_buyruk,
  input  logic [N:0]                  alu_sonuc,
  output logic                        cikis_gecerli,
  output logic [N:0]                  cikis_sonuc,
  input  logic                        cikis_hazir,
  output logic [$clog2(DERINLIK):0]   doluluk
`ifdef ISLEM_SAYACI_EN
  ,
  output logic [15:0]                 islem_sayisi
`endif
);

  localparam int BW = 2*N + 3;
  localparam int RW = N + 1;
  localparam int AW = $clog2(DERINLIK);
  localparam logic [AW:0] DOLU = (AW+1)'(DERINLIK);

  typedef enum logic [1:0] {
    BOS,
    HESAP,
    SONUC
  } durum_t;

  durum_t          r_durum;
  logic [BW-1:0]   r_mem [DERINLIK];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_doluluk;
  logic [BW-1:0]   r_alu_buyruk;
  logic [RW-1:0]   r_cikis_sonuc;
  logic            r_cikis_gecerli;

  logic            w_push;
  logic            w_pop;
  logic            w_bos_degil;
  logic [BW-1:0]   w_bas;

  // Ready depends on occupancy only; a pop in the same cycle does not free a slot early.
  assign giris_hazir   = (r_doluluk < DOLU);
  assign w_push        = giris_gecerli & giris_hazir;
  assign w_bos_degil   = (r_doluluk != '0);
  assign w_bas         = r_mem[r_rd_ptr];

  assign doluluk       = r_doluluk;
  assign alu_buyruk    = r_alu_buyruk;
  assign cikis_sonuc   = r_cikis_sonuc;
  assign cikis_gecerli = r_cikis_gecerli;

  always_comb begin
    w_pop = 1'b0;
    case (r_durum)
      BOS:     w_pop = w_bos_degil;
      SONUC:   w_pop = cikis_hazir & w_bos_degil;
      default: w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= giris_buyruk;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_doluluk <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_doluluk <= r_doluluk + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_doluluk <= r_doluluk - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_durum         <= BOS;
      r_alu_buyruk    <= '0;
      r_cikis_sonuc   <= '0;
      r_cikis_gecerli <= 1'b0;
    end else begin
      case (r_durum)
        BOS: begin
          if (w_pop) begin
            r_alu_buyruk <= w_bas;
            r_durum      <= HESAP;
          end
        end
        HESAP: begin
          r_cikis_sonuc   <= alu_sonuc;
          r_cikis_gecerli <= 1'b1;
          r_durum         <= SONUC;
        end
        SONUC: begin
          if (cikis_hazir) begin
            r_cikis_gecerli <= 1'b0;
            if (w_pop) begin
              r_alu_buyruk <= w_bas;
              r_durum      <= HESAP;
            end else begin
              r_durum <= BOS;
            end
          end
        end
        default: r_durum <= BOS;
      endcase
    end
  end

`ifdef ISLEM_SAYACI_EN
  logic [15:0] r_islem_sayisi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_islem_sayisi <= '0;
    end else if (r_cikis_gecerli && cikis_hazir) begin
      r_islem_sayisi <= r_islem_sayisi + 16'd1;
    end
  end

  assign islem_sayisi = r_islem_sayisi;
`endif

endmodule

// File: tb/tb_buyruk_kuyrugu.sv
// Directed bench for buyruk_kuyrugu (N=3, DERINLIK=4) with a behavioural ALU on the alu_* loop.
module tb_buyruk_kuyrugu;

  logic       clk;
  logic       rst_n;
  logic       giris_gecerli;
  logic [8:0] giris_buyruk;
  logic       giris_hazir;
  logic [8:0] alu_buyruk;
  logic [3:0] alu_sonuc;
  logic       cikis_gecerli;
  logic [3:0] cikis_sonuc;
  logic       cikis_hazir;
  logic [2:0] doluluk;
`ifdef ISLEM_SAYACI_EN
  logic [15:0] islem_sayisi;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  buyruk_kuyrugu #(.N(3), .DERINLIK(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .giris_gecerli (giris_gecerli),
    .giris_buyruk  (giris_buyruk),
    .giris_hazir   (giris_hazir),
    .alu_buyruk    (alu_buyruk),
    .alu_sonuc     (alu_sonuc),
    .cikis_gecerli (cikis_gecerli),
    .cikis_sonuc   (cikis_sonuc),
    .cikis_hazir   (cikis_hazir),
    .doluluk       (doluluk)
`ifdef ISLEM_SAYACI_EN
    ,
    .islem_sayisi  (islem_sayisi)
`endif
  );

  // ALU stand-in: ADD, SUB, AND, OR, XOR on 3-bit operands into a 4-bit result
  function automatic logic [3:0] alu_f(input logic [8:0] w);
    logic [3:0] a;
    logic [3:0] b;
    a = {1'b0, w[5:3]};
    b = {1'b0, w[2:0]};
    case (w[8:6])
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return 4'd0;
    endcase
  endfunction

  assign alu_sonuc = alu_f(alu_buyruk);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    giris_gecerli = 1'b0;
    giris_buyruk  = '0;
    cikis_hazir   = 1'b0;
    rst_n         = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (doluluk !== 3'd0) begin errors++; $display("FAIL reset_doluluk: got %0d expected 0", doluluk); end
    checks++;
    if (giris_hazir !== 1'b1) begin errors++; $display("FAIL reset_hazir: got %b expected 1", giris_hazir); end
    checks++;
    if (alu_buyruk !== 9'h000 || cikis_sonuc !== 4'h0 || cikis_gecerli !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got alu=%h sonuc=%h gecerli=%b expected 000 0 0", alu_buyruk, cikis_sonuc, cikis_gecerli);
    end
  endtask

  task automatic test_single_add();
    cikis_hazir   = 1'b1;
    giris_gecerli = 1'b1;
    giris_buyruk  = 9'b000_011_010;
    step();
    giris_gecerli = 1'b0;
    checks++;
    if (doluluk !== 3'd1 || alu_buyruk !== 9'h000) begin
      errors++;
      $display("FAIL add_no_bypass: got doluluk=%0d alu=%h expected 1 000", doluluk, alu_buyruk);
    end
    step();
    checks++;
    if (alu_buyruk !== 9'h01A || cikis_gecerli !== 1'b0 || doluluk !== 3'd0) begin
      errors++;
      $display("FAIL add_issue: got alu=%h gecerli=%b doluluk=%0d expected 01a 0 0", alu_buyruk, cikis_gecerli, doluluk);
    end
    step();
    checks++;
    if (cikis_gecerli !== 1'b1 || cikis_sonuc !== 4'b0101) begin
      errors++;
      $display("FAIL add_result: got gecerli=%b sonuc=%b expected 1 0101", cikis_gecerli, cikis_sonuc);
    end
    step();
    checks++;
    if (cikis_gecerli !== 1'b0 || alu_buyruk !== 9'h01A) begin
      errors++;
      $display("FAIL add_consumed: got gecerli=%b alu=%h expected 0 01a", cikis_gecerli, alu_buyruk);
    end
  endtask

  task automatic test_back_to_back();
    cikis_hazir   = 1'b1;
    giris_gecerli = 1'b1;
    giris_buyruk  = 9'b001_010_011;
    step();
    giris_buyruk  = 9'b010_110_011;
    step();
    giris_gecerli = 1'b0;
    step();
    checks++;
    if (cikis_gecerli !== 1'b1 || cikis_sonuc !== 4'b1111) begin
      errors++;
      $display("FAIL b2b_sub: got gecerli=%b sonuc=%b expected 1 1111", cikis_gecerli, cikis_sonuc);
    end
    step();
    checks++;
    if (cikis_gecerli !== 1'b0 || alu_buyruk !== 9'b010_110_011) begin
      errors++;
      $display("FAIL b2b_gap: got gecerli=%b alu=%h expected 0 %h", cikis_gecerli, alu_buyruk, 9'b010_110_011);
    end
    step();
    checks++;
    if (cikis_gecerli !== 1'b1 || cikis_sonuc !== 4'b0010) begin
      errors++;
      $display("FAIL b2b_and: got gecerli=%b sonuc=%b expected 1 0010", cikis_gecerli, cikis_sonuc);
    end
    step();
    checks++;
    if (cikis_gecerli !== 1'b0 || doluluk !== 3'd0) begin
      errors++;
      $display("FAIL b2b_idle: got gecerli=%b doluluk=%0d expected 0 0", cikis_gecerli, doluluk);
    end
  endtask

  task automatic test_full_hold();
    logic [8:0] w [6];
    logic [3:0] exp_q [$];
    int acc;
    int got;
    int last;
    int budget;
    w[0] = 9'b000_001_001; w[1] = 9'b001_111_010; w[2] = 9'b010_101_110;
    w[3] = 9'b011_100_001; w[4] = 9'b100_110_011; w[5] = 9'b000_111_111;
    acc = 0;
    cikis_hazir = 1'b0;
    for (int i = 0; i < 6; i++) begin
      giris_gecerli = 1'b1;
      giris_buyruk  = w[i];
      if (giris_hazir) begin
        acc++;
        exp_q.push_back(alu_f(w[i]));
      end
      step();
    end
    giris_gecerli = 1'b0;
    checks++;
    if (acc !== 5) begin errors++; $display("FAIL full_accept: got %0d expected 5", acc); end
    checks++;
    if (giris_hazir !== 1'b0 || doluluk !== 3'd4) begin
      errors++;
      $display("FAIL full_state: got hazir=%b doluluk=%0d expected 0 4", giris_hazir, doluluk);
    end
    repeat (3) step();
    checks++;
    if (cikis_gecerli !== 1'b1 || cikis_sonuc !== 4'b0010) begin
      errors++;
      $display("FAIL full_held: got gecerli=%b sonuc=%b expected 1 0010", cikis_gecerli, cikis_sonuc);
    end
    cikis_hazir = 1'b1;
    got = 0; last = -1; budget = 0;
    while (got < 5 && budget < 40 && exp_q.size() > got) begin
      if (cikis_gecerli) begin
        checks++;
        if (cikis_sonuc !== exp_q[got]) begin
          errors++;
          $display("FAIL drain_value[%0d]: got %b expected %b", got, cikis_sonuc, exp_q[got]);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 2) begin
            errors++;
            $display("FAIL drain_spacing[%0d]: got %0d cycles expected 2", got, cyc - last);
          end
        end
        last = cyc;
        got++;
      end
      step();
      budget++;
    end
    checks++;
    if (got != 5) begin errors++; $display("FAIL drain_count: got %0d expected 5", got); end
    step();
  endtask

  task automatic test_wrap_stream();
    logic [3:0] exp_r [14];
    int pushed;
    int got;
    int budget;
    int over;
    bit full_seen;
    pushed = 0; got = 0; budget = 0; over = 0; full_seen = 0;
    cikis_hazir = 1'b1;
    for (int i = 0; i < 14; i++) begin
      exp_r[i] = alu_f({3'(i % 5), 3'(i), 3'(13 - i)});
    end
    while (got < 14 && budget < 200) begin
      if (pushed < 14) begin
        giris_gecerli = 1'b1;
        giris_buyruk  = {3'(pushed % 5), 3'(pushed), 3'(13 - pushed)};
      end else begin
        giris_gecerli = 1'b0;
      end
      if (doluluk > 3'd4) over++;
      if (doluluk == 3'd4 && giris_hazir === 1'b0) full_seen = 1;
      if (giris_gecerli && giris_hazir) pushed++;
      if (cikis_gecerli && cikis_hazir) begin
        checks++;
        if (cikis_sonuc !== exp_r[got]) begin
          errors++;
          $display("FAIL wrap_value[%0d]: got %b expected %b", got, cikis_sonuc, exp_r[got]);
        end
        got++;
      end
      step();
      budget++;
    end
    giris_gecerli = 1'b0;
    checks++;
    if (got != 14 || pushed != 14) begin
      errors++;
      $display("FAIL wrap_count: got results=%0d pushed=%0d expected 14 14", got, pushed);
    end
    checks++;
    if (over != 0) begin errors++; $display("FAIL wrap_overflow: got %0d over-full cycles expected 0", over); end
    checks++;
    if (!full_seen) begin errors++; $display("FAIL wrap_full_seen: got 0 expected 1"); end
    repeat (2) step();
    checks++;
    if (doluluk !== 3'd0 || cikis_gecerli !== 1'b0) begin
      errors++;
      $display("FAIL wrap_empty: got doluluk=%0d gecerli=%b expected 0 0", doluluk, cikis_gecerli);
    end
  endtask

  task automatic test_reset_midstream();
    int seen;
    int budget;
    bit ok;
    cikis_hazir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      giris_gecerli = 1'b1;
      giris_buyruk  = {3'd0, 3'(i + 1), 3'd1};
      step();
    end
    giris_gecerli = 1'b0;
    checks++;
    if (doluluk !== 3'd3 || cikis_gecerli !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: got doluluk=%0d gecerli=%b expected 3 1", doluluk, cikis_gecerli);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (doluluk !== 3'd0 || giris_hazir !== 1'b1 || alu_buyruk !== 9'h000 ||
        cikis_gecerli !== 1'b0 || cikis_sonuc !== 4'h0) begin
      errors++;
      $display("FAIL mid_async_reset: got doluluk=%0d hazir=%b alu=%h gecerli=%b sonuc=%h expected 0 1 000 0 0",
               doluluk, giris_hazir, alu_buyruk, cikis_gecerli, cikis_sonuc);
    end
    step();
    rst_n = 1'b1;
    cikis_hazir = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (cikis_gecerli !== 1'b0 || alu_buyruk !== 9'h000) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL mid_quiet: got %0d active cycles expected 0", seen); end
    giris_gecerli = 1'b1;
    giris_buyruk  = 9'b100_101_011;
    step();
    giris_gecerli = 1'b0;
    budget = 0; ok = 0;
    while (!ok && budget < 6) begin
      if (cikis_gecerli) ok = 1; else begin step(); budget++; end
    end
    checks++;
    if (!ok || cikis_sonuc !== 4'b0110) begin
      errors++;
      $display("FAIL mid_recover: got valid=%b sonuc=%b expected 1 0110", ok, cikis_sonuc);
    end
    repeat (2) step();
  endtask

`ifdef ISLEM_SAYACI_EN
  task automatic test_counter();
    apply_reset();
    cikis_hazir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      giris_gecerli = 1'b1;
      giris_buyruk  = {3'd0, 3'(i), 3'd2};
      step();
    end
    giris_gecerli = 1'b0;
    repeat (8) step();
    checks++;
    if (islem_sayisi !== 16'd3) begin errors++; $display("FAIL cnt_three: got %0d expected 3", islem_sayisi); end
    force dut.r_islem_sayisi = 16'hFFFF;
    step();
    release dut.r_islem_sayisi;
    step();
    checks++;
    if (islem_sayisi !== 16'hFFFF) begin errors++; $display("FAIL cnt_preload: got %h expected ffff", islem_sayisi); end
    giris_gecerli = 1'b1;
    giris_buyruk  = 9'b000_001_001;
    step();
    giris_gecerli = 1'b0;
    repeat (5) step();
    checks++;
    if (islem_sayisi !== 16'h0000) begin errors++; $display("FAIL cnt_wrap: got %h expected 0000", islem_sayisi); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_full_hold();
    test_wrap_stream();
    test_reset_midstream();
`ifdef ISLEM_SAYACI_EN
    test_counter();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/buyruk_kuyrugu.md
Name: buyruk_kuyrugu

Overview:
Instruction-issue stage that sits directly upstream of the combinational ALU (`bibp`).
- Accepts instruction words (`buyruk`) over a valid/ready handshake and buffers them in a FIFO.
- Presents one word at a time to the ALU on a registered bus.
- Captures the ALU's combinational result one cycle later and holds it on a valid/ready output until it is consumed.
- Decouples the instruction producer from the result consumer; results leave in strict program order.

Parameters:
- N, 3: ALU operand parameter. Must match the ALU. Instruction word width BW = 2N+3; result width RW = N+1.
- DERINLIK, 4: FIFO depth in words. Power of two, ≥2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- giris_gecerli  input  1  upstream instruction valid.
- giris_buyruk  input  BW  upstream instruction word: [BW-1:BW-3] opcode, then operand A, then operand B.
- giris_hazir  output  1  FIFO can accept a word.
- alu_buyruk  output  BW  registered instruction driven into the ALU.
- alu_sonuc  input  RW  combinational result returned from the ALU.
- cikis_gecerli  output  1  captured result valid.
- cikis_sonuc  output  RW  captured result.
- cikis_hazir  input  1  downstream accepts the result.
- doluluk  output  clog2(DERINLIK)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FIFO empty; doluluk=0; giris_hazir=1.
  - alu_buyruk=0, cikis_sonuc=0, cikis_gecerli=0; FSM=BOS.
  - Reset mid-operation discards every buffered and in-flight word. No result is emitted for them.
- FIFO:
  - Push when giris_gecerli & giris_hazir at the clock edge.
  - giris_hazir = (doluluk < DERINLIK). It depends on occupancy only; there is no same-cycle pop credit, so a full FIFO deasserts ready even on a pop cycle.
  - Push and pop in the same cycle: occupancy unchanged, both pointers advance.
  - Pointers wrap modulo DERINLIK.
  - No bypass: a word pushed into an empty FIFO is popped no earlier than the following edge.
  - Pushing while not ready is ignored; the word is not stored.
- FSM states:
  - BOS (idle): if doluluk>0, pop the head word into alu_buyruk, then go to HESAP. Otherwise stay in BOS.
  - HESAP: alu_buyruk is stable for one full cycle. At the edge, cikis_sonuc←alu_sonuc, cikis_gecerli←1, then go to SONUC.
  - SONUC: cikis_sonuc and cikis_gecerli are held stable while cikis_hazir=0.
    - On cikis_hazir=1 with doluluk>0: pop the next word into alu_buyruk and go to HESAP.
    - On cikis_hazir=1 with doluluk=0: go to BOS.
    - In both cases cikis_gecerli←0 at that edge.
- Latency and throughput:
  - A word accepted at edge k appears on alu_buyruk after edge k+1 (when the FSM is idle).
  - cikis_gecerli rises after edge k+2.
  - Sustained throughput is one result per 2 cycles.
- alu_buyruk retains its last value in BOS and SONUC; it changes only on a pop.
- All output widths are exactly as listed. Arithmetic (wrap, sign) is the ALU's responsibility; this block copies alu_sonuc unchanged.

Optional Feature:
Macro ISLEM_SAYACI_EN.
- Defined: adds output port islem_sayisi [15:0].
  - Increments on every cikis_gecerli & cikis_hazir handshake.
  - Wraps 16'hFFFF→0.
  - Reset value is 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
All scenarios use N=3, DERINLIK=4.
1. Reset, then push 9'b000_011_010 (ADD 3+2), cikis_hazir=1 → alu_buyruk=0x01A after 1 cycle; cikis_gecerli=1 with cikis_sonuc=4'b0101 after 2 cycles; low the following cycle.
2. Push SUB 9'b001_010_011 (2−3) → cikis_sonuc=4'b1111; then AND 9'b010_110_011 → 4'b0010. Results appear in push order, 2 cycles apart.
3. Hold cikis_hazir=0 and offer 6 words back-to-back → exactly 5 are accepted: 1 in the ALU path, 4 in the FIFO. giris_hazir=0 with doluluk=4. The first result is held stable. Release cikis_hazir → all 5 results drain in order, one every 2 cycles.
4. With the FIFO full and cikis_hazir=1, keep giris_gecerli=1 → occupancy never exceeds 4, no word is lost or duplicated, and pointers wrap correctly over ≥12 words.
5. Assert rst_n=0 mid-stream (FSM in SONUC, doluluk=3) → outputs go to reset values immediately. After release, nothing is emitted until new pushes arrive.
6. With ISLEM_SAYACI_EN defined, complete 3 handshakes → islem_sayisi=3. Preload the counter to 16'hFFFF via 65535 handshakes (or force), then one more handshake → 0.
